dino_collision_ctrl: RTL and testbench

- Consumer end of the obstacle LED line: samples `ledLine` from `obstacle_generator` and tracks the dino's jump state from the jump button.
- Detects collisions, counts cleared obstacles and latches game-over.
- Sits between `obstacle_generator` and the display/score logic in the DINO game top level.

---
 rtl/dino_collision_ctrl.sv | 115 +++++++++++
 tb/tb_dino_collision_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dino_collision_ctrl.sv
// Dino jump/collision controller: synchronizes the jump button, watches the obstacle
// line scroll past the player bit, counts cleared obstacles and latches game-over.
module dino_collision_ctrl #(
  parameter int PLAYER_POS = 0,
  parameter int JUMP_STEPS = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         ledLine,
  input  logic               jump_btn,
  input  logic               restart,
  output logic               dino_air,
  output logic               collision,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {RUN, AIR, OVER} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt, cnt_dec;
  logic [SCORE_W-1:0] score_nxt;
  logic               coll_nxt;
  logic               sync_p0, sync_p1, btn_p2, jump_req;
  logic [7:0]         line_q;
  logic               step, obs_now, obs_prev;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  assign step     = (ledLine != line_q);
  assign obs_now  = ledLine[PLAYER_POS];
  assign obs_prev = line_q[PLAYER_POS];
  assign cnt_dec  = cnt - 4'd1;

  // Button synchronizer, edge detect and registered request pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      btn_p2   <= 1'b0;
      jump_req <= 1'b0;
      line_q   <= 8'h00;
    end else begin
      sync_p0  <= jump_btn;
      sync_p1  <= sync_p0;
      btn_p2   <= sync_p1;
      jump_req <= sync_p1 & ~btn_p2;
      line_q   <= ledLine;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    score_nxt = score;
    coll_nxt  = 1'b0;
    if (restart) begin
      state_nxt = RUN;
      cnt_nxt   = 4'd0;
      score_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if (obs_now) begin
            state_nxt = OVER;
            coll_nxt  = 1'b1;
          end else if (jump_req) begin
            state_nxt = AIR;
            cnt_nxt   = 4'(JUMP_STEPS);
          end
        end
        AIR: begin
          // Scoring and landing are evaluated independently in the same cycle
          if (obs_prev && !obs_now)
            score_nxt = sat_inc(score);
          if (step) begin
            cnt_nxt = cnt_dec;
            if (cnt_dec == 4'd0) begin
              if (obs_now) begin
                state_nxt = OVER;
                coll_nxt  = 1'b1;
              end else begin
                state_nxt = RUN;
              end
            end
          end
        end
        OVER:    state_nxt = OVER;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= 4'd0;
      score     <= '0;
      collision <= 1'b0;
      dino_air  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      score     <= score_nxt;
      collision <= coll_nxt;
      dino_air  <= (state_nxt == AIR);
      game_over <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_dino_collision_ctrl.sv
// Scoreboard bench for dino_collision_ctrl: stimulus pushes model predictions,
// a monitor pops and compares them one cycle at a time.
module tb_dino_collision_ctrl;

  localparam int PP = 0;
  localparam int JS = 3;
  localparam int SW = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    ledLine;
  logic          jump_btn;
  logic          restart;
  logic          dino_air;
  logic          collision;
  logic          game_over;
  logic [SW-1:0] score;

  int total = 0;
  int bad   = 0;
  int cycno = 0;

  typedef struct {
    bit air;
    bit coll;
    bit go;
    int sc;
  } exp_t;
  exp_t exq[$];

  // Reference model: game phase 0=running,1=airborne,2=over
  int       m_phase, m_left, m_score;
  bit       m_coll;
  bit [4:0] m_btn_hist;
  bit [7:0] m_last_line;

  dino_collision_ctrl #(.PLAYER_POS(PP), .JUMP_STEPS(JS), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .ledLine(ledLine), .jump_btn(jump_btn),
    .restart(restart), .dino_air(dino_air), .collision(collision),
    .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit rs, input bit [7:0] l, input bit b);
    bit pressed, moved, here, was;
    m_coll = 1'b0;
    if (!r) begin
      m_phase = 0; m_left = 0; m_score = 0;
      m_btn_hist = '0; m_last_line = 8'h00;
      return;
    end
    m_btn_hist = {m_btn_hist[3:0], b};
    pressed = m_btn_hist[3] && !m_btn_hist[4];
    moved   = (l != m_last_line);
    here    = l[PP];
    was     = m_last_line[PP];
    if (rs) begin
      m_phase = 0; m_left = 0; m_score = 0;
    end else if (m_phase == 0) begin
      if (here) begin m_phase = 2; m_coll = 1'b1; end
      else if (pressed) begin m_phase = 1; m_left = JS; end
    end else if (m_phase == 1) begin
      if (was && !here && m_score < SMAX) m_score++;
      if (moved) begin
        m_left--;
        if (m_left == 0) begin
          if (here) begin m_phase = 2; m_coll = 1'b1; end
          else m_phase = 0;
        end
      end
    end
    m_last_line = l;
  endtask

  task automatic cyc(input bit r, input bit rs, input bit [7:0] l, input bit b);
    exp_t e;
    @(negedge clk);
    reset = r; restart = rs; ledLine = l; jump_btn = b;
    model_edge(r, rs, l, b);
    e.air = (m_phase == 1); e.coll = m_coll; e.go = (m_phase == 2); e.sc = m_score;
    exq.push_back(e);
  endtask

  task automatic async_reset(input bit [7:0] l);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (dino_air !== 1'b0 || collision !== 1'b0 || game_over !== 1'b0 || score !== '0) begin
      bad++;
      $display("FAIL async_reset got air=%0b coll=%0b go=%0b score=%0d want all 0",
               dino_air, collision, game_over, score);
    end
    model_edge(1'b0, 1'b0, l, 1'b0);
    cyc(1'b0, 1'b0, l, 1'b0);
    cyc(1'b0, 1'b0, l, 1'b0);
  endtask

  task automatic do_jump(input bit [7:0] l);
    repeat (3) cyc(1'b1, 1'b0, l, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, l, 1'b0);
  endtask

  task automatic do_clear();
    do_jump(8'h00);
    repeat (2) cyc(1'b1, 1'b0, 8'h01, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 8'h80, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    cycno++;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      total++;
      if (dino_air !== e.air || collision !== e.coll || game_over !== e.go ||
          score !== SW'(e.sc)) begin
        bad++;
        $display("FAIL cyc%0d outputs got air=%0b coll=%0b go=%0b score=%0d want air=%0b coll=%0b go=%0b score=%0d",
                 cycno, dino_air, collision, game_over, score, e.air, e.coll, e.go, e.sc);
      end
    end
  end

  initial begin
    bit [7:0] rl;
    bit       rb;
    reset = 1'b0; restart = 1'b0; ledLine = 8'h00; jump_btn = 1'b0;
    model_edge(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Obstacle walks in with no jump
    rl = 8'h80;
    for (int i = 0; i < 8; i++) begin
      repeat (4) cyc(1'b1, 1'b0, rl, 1'b0);
      rl = rl >> 1;
    end
    repeat (2) cyc(1'b1, 1'b1, 8'h00, 1'b0);

    // Clear five obstacles, then reset in mid-air
    repeat (5) do_clear();
    do_jump(8'h00);
    repeat (2) cyc(1'b1, 1'b0, 8'h01, 1'b0);
    async_reset(8'h01);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Saturation of the narrow score counter
    repeat (9) do_clear();

    // Landing on an obstacle, then restart from game over
    do_jump(8'h00);
    cyc(1'b1, 1'b0, 8'h80, 1'b0);
    cyc(1'b1, 1'b0, 8'h40, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 8'h01, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Full line right out of reset
    async_reset(8'hFF);
    repeat (3) cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);

    // Randomized play
    rl = 8'h00; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rs;
      if (i % 4 == 0) rl = {($urandom_range(0, 4) == 0), rl[7:1]};
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      rs = (m_phase == 2 && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 599) == 0) async_reset(rl);
      cyc(1'b1, rs, rl, rb);
    end

    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
